// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: round-robin between the pipeline memory stage (m)
// and the loader port (l) in front of a synchronous-read 64-bit data memory.
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned AW        = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m_req,
  input  logic          m_we,
  input  logic [63:0]   m_addr,
  input  logic [63:0]   m_wdata,
  output logic [63:0]   m_rdata,
  output logic          m_ack,
  output logic          m_err,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [63:0]   l_addr,
  input  logic [63:0]   l_wdata,
  output logic [63:0]   l_rdata,
  output logic          l_ack,
  output logic          l_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [63:0]   mem_wdata,
  input  logic [63:0]   mem_rdata
);

  localparam int unsigned DW = 64;
  // Highest byte address at which a full 8-byte word still fits.
  localparam logic [DW-1:0] LAST_OK = DW'(MEM_BYTES - 8);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic            r_fav_l;
  logic            r_owner_l;
  logic            r_we;
  logic            r_m_ack;
  logic            r_l_ack;
  logic            r_m_err;
  logic            r_l_err;
  logic            r_mem_en;
  logic            r_mem_we;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_wdata;
  logic [DW-1:0]   r_m_rdata;
  logic [DW-1:0]   r_l_rdata;

  logic            w_grant_l;
  logic            w_sel_we;
  logic [DW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_wdata;
  logic            w_addr_ok;
  logic            w_start;
  logic            w_enter_done;
  logic            w_done_owner_l;
  logic            w_done_err;

  // Arbitration, address check and next-state decode.
  always_comb begin
    w_next         = r_state;
    w_grant_l      = l_req & (~m_req | r_fav_l);
    w_sel_we       = w_grant_l ? l_we    : m_we;
    w_sel_addr     = w_grant_l ? l_addr  : m_addr;
    w_sel_wdata    = w_grant_l ? l_wdata : m_wdata;
    w_addr_ok      = (w_sel_addr <= LAST_OK);
    w_start        = 1'b0;
    w_done_owner_l = r_owner_l;
    w_done_err     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (m_req | l_req) begin
          w_start        = 1'b1;
          w_next         = w_addr_ok ? S_ISSUE : S_DONE;
          w_done_owner_l = w_grant_l;
          w_done_err     = ~w_addr_ok;
        end
      end
      S_ISSUE:   w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
    w_enter_done = (w_next == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fav_l     <= 1'b0;
      r_owner_l   <= 1'b0;
      r_we        <= 1'b0;
      r_m_ack     <= 1'b0;
      r_l_ack     <= 1'b0;
      r_m_err     <= 1'b0;
      r_l_err     <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_m_rdata   <= '0;
      r_l_rdata   <= '0;
    end else begin
      r_mem_en <= w_start & w_addr_ok;
      r_mem_we <= w_start & w_addr_ok & w_sel_we;
      r_m_ack  <= w_enter_done & ~w_done_owner_l;
      r_l_ack  <= w_enter_done &  w_done_owner_l;
      r_m_err  <= w_enter_done & ~w_done_owner_l & w_done_err;
      r_l_err  <= w_enter_done &  w_done_owner_l & w_done_err;
      if (w_start) begin
        r_owner_l <= w_grant_l;
        r_we      <= w_sel_we;
        r_fav_l   <= ~w_grant_l;
        if (w_addr_ok) begin
          r_mem_addr  <= w_sel_addr[AW-1:0];
          r_mem_wdata <= w_sel_wdata;
        end
      end
      // Read data is valid in CAPTURE, one cycle after the ISSUE strobe.
      if ((r_state == S_CAPTURE) && !r_we) begin
        if (r_owner_l) begin
          r_l_rdata <= mem_rdata;
        end else begin
          r_m_rdata <= mem_rdata;
        end
      end
    end
  end

  assign m_rdata   = r_m_rdata;
  assign m_ack     = r_m_ack;
  assign m_err     = r_m_err;
  assign l_rdata   = r_l_rdata;
  assign l_ack     = r_l_ack;
  assign l_err     = r_l_err;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule
